decode_branch_unit: RTL
=======================

# decode_branch_unit

Decode-side partner of the instruction fetch memory. Each cycle it accepts the 32-bit `Instruccion` word and the `Done` flag from fetch, and registers the decoded fields for execute. It resolves branches and drives `branchResultOut` back to fetch as a one-cycle redirect pulse. It squashes the wrong-path words fetch emits after a redirect and latches the halt condition.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `Instruccion`, in, 32: instruction word from fetch, one new word per cycle.
- `Done`, in, 1: halt opcode seen by fetch.
- `zero_flag`, in, 1: ALU zero flag, sampled in the same cycle as the branch word.
- `branchResultOut`, out, 7: redirect target. Value 0 means no redirect.
- `dec_valid`, out, 1: decoded fields are valid this cycle.
- `dec_opcode`, out, 5: field [31:27].
- `dec_rd`, out, 5: field [26:22].
- `dec_rs1`, out, 5: field [21:17].
- `dec_rs2`, out, 5: field [16:12].
- `dec_imm`, out, 12: field [11:0].
- `halted`, out, 1: sticky halt indicator.
- `branch_err`, out, 1: one-cycle pulse when a taken branch targets address 0.
- `retired_count`, out, CNT_W: number of valid words issued; saturates at all-ones.

## Operation
- Opcodes:
  - 01000 B: unconditional branch.
  - 01001 BEQ: taken when `zero_flag` = 1.
  - 01010 BNE: taken when `zero_flag` = 0.
  - 01011 HALT.
  - Every other opcode is non-branch.
- Branch target is `Instruccion[6:0]`, an absolute address.
- FSM states are RUN, SQUASH, HALT.
- RUN:
  - The incoming word is registered to the `dec_*` outputs with `dec_valid` = 1, and `retired_count` increments.
  - A taken branch with a nonzero target drives `branchResultOut` = target for exactly one cycle, loads `sq_cnt` = 2, and moves to SQUASH.
  - A taken branch with target 0 pulses `branch_err`, is treated as not taken, and is still issued.
  - `Done` = 1 moves to HALT. The word presented with `Done` is not issued.
- SQUASH:
  - The incoming word is dropped: `dec_valid` = 0, and `Done`, `zero_flag` and `retired_count` are ignored.
  - `sq_cnt` decrements each cycle. At 0 the FSM returns to RUN and the next word is issued.
- HALT:
  - Absorbing until `rst_n` asserts.
  - `dec_valid` = 0, `branchResultOut` = 0, `halted` = 1.
- `branchResultOut` never holds a nonzero value for two consecutive cycles.
- Branch words themselves are issued (`dec_valid` = 1) so execute can count or trace them.

## Timing
- All outputs are registered.
- Reset values: `branchResultOut` = 0, all `dec_*` = 0, `dec_valid` = 0, `halted` = 0, `branch_err` = 0, `retired_count` = 0, state = RUN, `sq_cnt` = 0.
- Decode latency is 1 cycle: a word visible in cycle N appears on `dec_*` after edge N+1.
- Redirect sequence for a taken branch visible in cycle N:
  - `branchResultOut` is nonzero after edge N+1.
  - Fetch samples it at edge N+2, and `branchResultOut` returns to 0 at that edge.
  - The words visible in cycles N+1 and N+2 are wrong-path and are squashed.
  - The word visible in cycle N+3 is the target instruction and is issued.
- Branch during SQUASH: ignored, because it is on the wrong path.
- `Done` during SQUASH: ignored. Fetch keeps running, so a wrong-path HALT must not stop the core.
- `rst_n` asserted mid-SQUASH or in HALT: immediate return to reset values with no pulse leakage.
- `retired_count` at all-ones stays there and does not wrap.

## Structure
- A shared package holds:
  - the opcode constants `OP_B`, `OP_BEQ`, `OP_BNE`, `OP_HALT`;
  - the field bit-position constants;
  - the state enum `dec_state_t`.
- Sub-module `branch_resolve`: combinational, takes opcode, `zero_flag` and target, and outputs `taken` and `target_zero`.
- The FSM, the squash counter and the output registers stay in `decode_branch_unit`.

## Test plan
- **Reset and straight-line code:** hold reset, then apply words with opcode 00001 for 5 cycles. Required: `dec_valid` = 1 from the second cycle, fields match each word, `retired_count` = 5, `branchResultOut` stays 0.
- **Unconditional branch:** B with target 7'd20 in cycle N. Required: `branchResultOut` = 20 for exactly one cycle, `dec_valid` = 0 for the two following words, the word in cycle N+3 is issued.
- **Conditional branches:** BEQ with `zero_flag` = 0 is not taken; BEQ with `zero_flag` = 1 and BNE with `zero_flag` = 0 each redirect. Check exact targets.
- **Branch to address 0:** taken B with target 0. Required: `branch_err` pulses, `branchResultOut` = 0, no squash.
- **Halt:**
  - `Done` = 1 in RUN: `halted` = 1 next cycle and stays set with `dec_valid` = 0 while `Instruccion` toggles.
  - `Done` = 1 during SQUASH: ignored.
- **Reset mid-operation:** assert `rst_n` during SQUASH and during HALT, and drive `retired_count` to saturation (small `CNT_W`). Required: all outputs return to reset values, and the counter holds at max.

Source files
------------

// File: rtl/decode_branch_unit_pkg.sv
// rtl/decode_branch_unit_pkg.sv - opcodes, field positions and FSM states for decode_branch_unit
package decode_branch_unit_pkg;

  localparam logic [4:0] OP_B    = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_BNE  = 5'b01010;
  localparam logic [4:0] OP_HALT = 5'b01011;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS1_HI = 21;
  localparam int RS1_LO = 17;
  localparam int RS2_HI = 16;
  localparam int RS2_LO = 12;
  localparam int IMM_HI = 11;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 6;
  localparam int TGT_LO = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALT   = 2'd2
  } dec_state_t;

endpackage

// File: rtl/decode_branch_unit_branch_resolve.sv
// rtl/decode_branch_unit_branch_resolve.sv - combinational branch taken / zero-target decision
module branch_resolve
  import decode_branch_unit_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic       zero_flag,
  input  logic [6:0] target,
  output logic       taken,
  output logic       target_zero
);

  always_comb begin
    taken = 1'b0;
    unique case (opcode)
      OP_B:    taken = 1'b1;
      OP_BEQ:  taken = zero_flag;
      OP_BNE:  taken = ~zero_flag;
      default: taken = 1'b0;
    endcase
    target_zero = (target == 7'd0);
  end

endmodule

// File: rtl/decode_branch_unit.sv
// rtl/decode_branch_unit.sv - decode registers, branch redirect, wrong-path squash and halt latch
module decode_branch_unit
  import decode_branch_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Instruccion,
  input  logic             Done,
  input  logic             zero_flag,
  output logic [6:0]       branchResultOut,
  output logic             dec_valid,
  output logic [4:0]       dec_opcode,
  output logic [4:0]       dec_rd,
  output logic [4:0]       dec_rs1,
  output logic [4:0]       dec_rs2,
  output logic [11:0]      dec_imm,
  output logic             halted,
  output logic             branch_err,
  output logic [CNT_W-1:0] retired_count
);

  dec_state_t state;
  logic [1:0] sq_cnt;
  logic       taken;
  logic       target_zero;
  logic [6:0] target;

  assign target = Instruccion[TGT_HI:TGT_LO];

  branch_resolve u_branch_resolve (
    .opcode      (Instruccion[OPC_HI:OPC_LO]),
    .zero_flag   (zero_flag),
    .target      (target),
    .taken       (taken),
    .target_zero (target_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_RUN;
      sq_cnt          <= 2'd0;
      branchResultOut <= 7'd0;
      dec_valid       <= 1'b0;
      dec_opcode      <= 5'd0;
      dec_rd          <= 5'd0;
      dec_rs1         <= 5'd0;
      dec_rs2         <= 5'd0;
      dec_imm         <= 12'd0;
      halted          <= 1'b0;
      branch_err      <= 1'b0;
      retired_count   <= '0;
    end else begin
      // Pulses default low so a redirect or error never lasts more than one cycle.
      branchResultOut <= 7'd0;
      branch_err      <= 1'b0;
      dec_valid       <= 1'b0;
      case (state)
        ST_RUN: begin
          if (Done) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            dec_valid  <= 1'b1;
            dec_opcode <= Instruccion[OPC_HI:OPC_LO];
            dec_rd     <= Instruccion[RD_HI:RD_LO];
            dec_rs1    <= Instruccion[RS1_HI:RS1_LO];
            dec_rs2    <= Instruccion[RS2_HI:RS2_LO];
            dec_imm    <= Instruccion[IMM_HI:IMM_LO];
            if (retired_count != {CNT_W{1'b1}})
              retired_count <= retired_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (taken && !target_zero) begin
              branchResultOut <= target;
              sq_cnt          <= 2'd2;
              state           <= ST_SQUASH;
            end else if (taken) begin
              branch_err <= 1'b1;
            end
          end
        end
        ST_SQUASH: begin
          // Leave on the cycle the count reaches zero so the target word is issued.
          sq_cnt <= sq_cnt - 2'd1;
          if (sq_cnt <= 2'd1)
            state <= ST_RUN;
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule
